// File: rtl/bus_a8_rd_drive_pkg.sv
// Shared definitions for the A8 read-side responder and its sibling bus
// monitor. The tick constants are positions within one A8 bus cycle,
// counted in clk200 periods from the synchronised phi2 falling edge.
//
// Contents:
//   TICK_BITS          width of the cycle tick counter
//   TICK_ADDRESS_VALID tick at which addr / rw_n / page_sel are sampled
//   TICK_DRIVE_ON      earliest tick at which the data driver may enable
//   TICK_DEADLINE      last tick at which fetched data is accepted
//   HOLD_TICKS         driver hold time after the next phi2 falling edge
//   DEFAULT_DATA       byte driven when the fetch misses its deadline
//   rd_state_t         responder state encoding
//   sat_inc8()         saturating 8-bit increment
package bus_a8_rd_drive_pkg;

  localparam int         TICK_BITS          = 7;
  localparam int         TICK_ADDRESS_VALID = 33;
  localparam int         TICK_DRIVE_ON      = 60;
  localparam int         TICK_DEADLINE      = 85;
  localparam int         HOLD_TICKS         = 3;
  localparam logic [7:0] DEFAULT_DATA       = 8'hFF;

  // Depth of the phi2 synchroniser; the edge detector looks at the two
  // oldest stages.
  localparam int         SYNC_STAGES        = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_READY = 3'd2,
    ST_DRIVE = 3'd3,
    ST_HOLD  = 3'd4
  } rd_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/bus_a8_rd_drive_timer.sv
// a8_cycle_timer: bus-cycle position tracker for the A8 bus.
//
// Synchronises phi2 (a8_clk) into the clk200 domain, detects its edges and
// counts clk200 ticks since the last falling edge. The counter saturates at
// all-ones so a stopped phi2 is visible as a pinned maximum.
//
// Ports:
//   clk200    in   200 MHz FPGA clock
//   a8_rst_n  in   asynchronous active-low reset
//   a8_clk    in   A8 phi2, asynchronous to clk200
//   rising    out  one-cycle pulse, synchronised phi2 rising edge
//   falling   out  one-cycle pulse, synchronised phi2 falling edge
//   ticks     out  clk200 ticks since the last falling edge (saturating)
//   ticks_sat out  ticks is pinned at its maximum
module a8_cycle_timer
  import bus_a8_rd_drive_pkg::*;
#(
  parameter int TICK_W = TICK_BITS
) (
  input  logic              clk200,
  input  logic              a8_rst_n,
  input  logic              a8_clk,
  output logic              rising,
  output logic              falling,
  output logic [TICK_W-1:0] ticks,
  output logic              ticks_sat
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [TICK_W-1:0]      ticks_reg;
  logic [TICK_W-1:0]      ticks_next;
  logic [1:0]             sync_edge;

  // Bit 0 takes the raw input; higher bits are progressively older samples.
  always_ff @(posedge clk200 or negedge a8_rst_n) begin
    if (!a8_rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], a8_clk};
    end
  end

  // Oldest pair: {older, newer}. 10 is a falling edge, 01 a rising edge.
  assign sync_edge = sync_reg[SYNC_STAGES-1 -: 2];
  assign falling   = (sync_edge == 2'b10);
  assign rising    = (sync_edge == 2'b01);
  assign ticks_sat = &ticks_reg;

  always_comb begin
    ticks_next = ticks_reg;
    if (falling) begin
      ticks_next = '0;
    end else if (!ticks_sat) begin
      ticks_next = ticks_reg + TICK_W'(1);
    end
  end

  always_ff @(posedge clk200 or negedge a8_rst_n) begin
    if (!a8_rst_n) begin
      ticks_reg <= '0;
    end else begin
      ticks_reg <= ticks_next;
    end
  end

  assign ticks = ticks_reg;

endmodule

// File: rtl/bus_a8_rd_drive.sv
// bus_a8_rd_drive: read-side responder for the A8 cartridge bus.
//
// For each A8 read of an FPGA-sourced page it samples the address at the
// address-valid tick, fetches the byte over a req/ack handshake, and drives
// it onto the A8 data bus from the drive-on tick until a short hold after
// the next phi2 falling edge. A fetch that misses the deadline drives
// DEFAULT_DATA instead and is counted; its acknowledge is swallowed later.
//
// Ports:
//   clk200        in   200 MHz FPGA clock
//   a8_rst_n      in   asynchronous active-low reset
//   a8_clk        in   A8 phi2, asynchronous to clk200
//   a8_rw_n       in   A8 read/write (1 = read)
//   a8_addr       in   A8 address bus
//   page_sel      in   1 = page a8_addr[15:8] is FPGA-sourced
//   mem_req       out  fetch request, held until mem_ack
//   mem_addr      out  fetch address, stable while mem_req = 1
//   mem_ack       in   one-cycle acknowledge, mem_rdata valid with it
//   mem_rdata     in   fetched byte
//   a8_data_out   out  byte for the A8 data bus
//   a8_data_oe    out  data bus driver enable (1 = drive)
//   timeout_count out  saturating count of deadline misses
module bus_a8_rd_drive
  import bus_a8_rd_drive_pkg::*;
(
  input  logic        clk200,
  input  logic        a8_rst_n,
  input  logic        a8_clk,
  input  logic        a8_rw_n,
  input  logic [15:0] a8_addr,
  input  logic        page_sel,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  a8_data_out,
  output logic        a8_data_oe,
  output logic [7:0]  timeout_count
);

  localparam logic [TICK_BITS-1:0] T_ADDR_VALID = TICK_BITS'(TICK_ADDRESS_VALID);
  localparam logic [TICK_BITS-1:0] T_DRIVE_ON   = TICK_BITS'(TICK_DRIVE_ON);
  localparam logic [TICK_BITS-1:0] T_DEADLINE   = TICK_BITS'(TICK_DEADLINE);
  localparam logic [TICK_BITS-1:0] T_HOLD       = TICK_BITS'(HOLD_TICKS);

  logic                 unused_rising;
  logic                 a8_falling;
  logic                 ticks_sat;
  logic [TICK_BITS-1:0] ticks;

  a8_cycle_timer #(
    .TICK_W (TICK_BITS)
  ) u_timer (
    .clk200    (clk200),
    .a8_rst_n  (a8_rst_n),
    .a8_clk    (a8_clk),
    .rising    (unused_rising),
    .falling   (a8_falling),
    .ticks     (ticks),
    .ticks_sat (ticks_sat)
  );

  rd_state_t   state_reg,    state_next;
  logic        mem_req_reg,  mem_req_next;
  logic [15:0] mem_addr_reg, mem_addr_next;
  logic [7:0]  data_reg,     data_next;
  logic        oe_reg,       oe_next;
  logic [7:0]  timeout_reg,  timeout_next;
  logic        pending_reg,  pending_next;

  logic rd_hit;
  logic late_ack;
  logic own_req;

  assign rd_hit   = (ticks == T_ADDR_VALID) && a8_rw_n && page_sel;
  // An ack while a missed request is still outstanding belongs to that
  // stale request, never to the current bus cycle.
  assign late_ack = pending_reg && mem_ack;
  // FETCH only waits for data when it has its own request in flight. If the
  // stale request was still open at address-valid time (or its ack landed in
  // that very cycle) nothing was issued and the cycle is a miss.
  assign own_req  = mem_req_reg && !pending_reg;

  always_comb begin
    state_next    = state_reg;
    mem_req_next  = mem_req_reg;
    mem_addr_next = mem_addr_reg;
    data_next     = data_reg;
    oe_next       = oe_reg;
    timeout_next  = timeout_reg;
    pending_next  = pending_reg;

    if (late_ack) begin
      mem_req_next = 1'b0;
      pending_next = 1'b0;
    end

    case (state_reg)
      ST_IDLE: begin
        if (rd_hit) begin
          state_next = ST_FETCH;
          if (!pending_reg) begin
            mem_addr_next = a8_addr;
            mem_req_next  = 1'b1;
          end
        end
      end

      // The deadline lies well below counter saturation, so a stopped phi2
      // during FETCH always leaves through the deadline path first.
      ST_FETCH: begin
        if (!own_req) begin
          data_next    = DEFAULT_DATA;
          timeout_next = sat_inc8(timeout_reg);
          state_next   = ST_READY;
        end else if (mem_ack) begin
          data_next    = mem_rdata;
          mem_req_next = 1'b0;
          state_next   = ST_READY;
        end else if (ticks >= T_DEADLINE) begin
          // Request stays high; the eventual ack is swallowed as a late ack.
          data_next    = DEFAULT_DATA;
          timeout_next = sat_inc8(timeout_reg);
          pending_next = 1'b1;
          state_next   = ST_READY;
        end
      end

      ST_READY: begin
        if (ticks_sat) begin
          oe_next    = 1'b0;
          state_next = ST_IDLE;
        end else if (ticks >= T_DRIVE_ON) begin
          oe_next    = 1'b1;
          state_next = ST_DRIVE;
        end
      end

      ST_DRIVE: begin
        if (a8_falling) begin
          state_next = ST_HOLD;
        end else if (ticks_sat) begin
          oe_next    = 1'b0;
          state_next = ST_IDLE;
        end
      end

      ST_HOLD: begin
        if (ticks == T_HOLD) begin
          oe_next    = 1'b0;
          state_next = ST_IDLE;
        end
      end

      default: begin
        oe_next    = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk200 or negedge a8_rst_n) begin
    if (!a8_rst_n) begin
      state_reg    <= ST_IDLE;
      mem_req_reg  <= 1'b0;
      mem_addr_reg <= '0;
      data_reg     <= '0;
      oe_reg       <= 1'b0;
      timeout_reg  <= '0;
      pending_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      mem_req_reg  <= mem_req_next;
      mem_addr_reg <= mem_addr_next;
      data_reg     <= data_next;
      oe_reg       <= oe_next;
      timeout_reg  <= timeout_next;
      pending_reg  <= pending_next;
    end
  end

  assign mem_req       = mem_req_reg;
  assign mem_addr      = mem_addr_reg;
  assign a8_data_out   = data_reg;
  assign a8_data_oe    = oe_reg;
  assign timeout_count = timeout_reg;

endmodule

// File: tb/tb_bus_a8_rd_drive.sv
// Testbench for bus_a8_rd_drive. phi2 is driven in step with clk200 so that
// the tick position of every stimulus and sample is exact: a falling edge
// driven on a clk200 negedge makes the DUT tick counter read 0 three clk200
// edges later. All inputs change and all outputs are sampled on negedges.
module tb_bus_a8_rd_drive;

  logic        clk200;
  logic        a8_rst_n;
  logic        a8_clk;
  logic        a8_rw_n;
  logic [15:0] a8_addr;
  logic        page_sel;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [7:0]  a8_data_out;
  logic        a8_data_oe;
  logic [7:0]  timeout_count;

  int checks;
  int failures;

  bus_a8_rd_drive dut (
    .clk200        (clk200),
    .a8_rst_n      (a8_rst_n),
    .a8_clk        (a8_clk),
    .a8_rw_n       (a8_rw_n),
    .a8_addr       (a8_addr),
    .page_sel      (page_sel),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .a8_data_out   (a8_data_out),
    .a8_data_oe    (a8_data_oe),
    .timeout_count (timeout_count)
  );

  initial clk200 = 1'b0;
  always #5 clk200 = ~clk200;

  // One A8 bus cycle: inputs, ack timing, and expected outcome.
  // ack_tick = -1 means no ack in this cycle; exp_oe_rise = -1 means the
  // driver must stay off.
  typedef struct {
    logic [15:0] addr;
    logic        rw_n;
    logic        page_sel;
    int          ack_tick;
    logic [7:0]  ack_data;
    logic        exp_req;
    logic        chk_addr;
    int          exp_oe_rise;
    logic [7:0]  exp_data;
    logic [7:0]  exp_timeout;
    logic        exp_req_end;
  } vec_t;

  localparam int NVEC    = 13;
  localparam int CYC_LEN = 110;

  vec_t vecs [NVEC];
  vec_t v_post;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Start a cycle from a known phase: drive phi2 low and advance until the
  // DUT tick counter reads 5.
  task automatic resync();
    a8_clk = 1'b0;
    repeat (8) @(negedge clk200);
  endtask

  // Entered on the negedge where ticks == 5; returns on the negedge where the
  // next cycle's ticks == 5, after the hold window of this cycle.
  task automatic run_cycle(input vec_t v, input string tag);
    int         oe_rise;
    int         hold_low;
    logic       data_ok;
    logic [7:0] seen;
    oe_rise  = -1;
    hold_low = -1;
    data_ok  = 1'b1;
    seen     = 8'h00;
    a8_addr  = v.addr;
    a8_rw_n  = v.rw_n;
    page_sel = v.page_sel;
    for (int t = 5; t < CYC_LEN; t++) begin
      if (t == 34) begin
        check({tag, "_req"}, 32'(mem_req), 32'(v.exp_req));
        if (v.chk_addr) check({tag, "_addr"}, 32'(mem_addr), 32'(v.addr));
      end
      if (a8_data_oe) begin
        if (oe_rise < 0) oe_rise = t;
        seen = a8_data_out;
        if (a8_data_out !== v.exp_data) data_ok = 1'b0;
      end
      mem_ack   = (t == v.ack_tick);
      mem_rdata = (t == v.ack_tick) ? v.ack_data : 8'h00;
      if (t == 55) a8_clk = 1'b1;
      if (t == CYC_LEN - 3) a8_clk = 1'b0;
      @(negedge clk200);
    end
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    for (int u = 0; u < 5; u++) begin
      if (a8_data_oe) begin
        if (a8_data_out !== v.exp_data) data_ok = 1'b0;
      end else if (hold_low < 0) begin
        hold_low = u;
      end
      @(negedge clk200);
    end
    check({tag, "_oe_rise"}, 32'(oe_rise), 32'(v.exp_oe_rise));
    check({tag, "_data"}, 32'(data_ok), 32'd1);
    if (v.exp_oe_rise >= 0) check({tag, "_hold"}, 32'(hold_low), 32'd4);
    check({tag, "_timeouts"}, 32'(timeout_count), 32'(v.exp_timeout));
    check({tag, "_req_end"}, 32'(mem_req), 32'(v.exp_req_end));
    $display("cycle %s addr=%h rw_n=%b sel=%b oe_rise=%0d data=%h timeouts=%0d req=%b",
             tag, v.addr, v.rw_n, v.page_sel, oe_rise, seen, timeout_count, mem_req);
  endtask

  initial begin
    int         oe_at_127;
    int         oe_at_128;
    logic       stop_data_ok;
    checks    = 0;
    failures  = 0;
    a8_rst_n  = 1'b0;
    a8_clk    = 1'b1;
    a8_rw_n   = 1'b1;
    a8_addr   = 16'h0000;
    page_sel  = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;

    //           addr     rw    sel   ack  data   req   chka  oe  exp    to    reqend
    vecs[0]  = '{16'hA012, 1'b1, 1'b1, 40,  8'h5A, 1'b1, 1'b1, 61, 8'h5A, 8'd0, 1'b0};
    vecs[1]  = '{16'h1234, 1'b0, 1'b1, -1,  8'h00, 1'b0, 1'b0, -1, 8'h00, 8'd0, 1'b0};
    vecs[2]  = '{16'h4321, 1'b1, 1'b0, -1,  8'h00, 1'b0, 1'b0, -1, 8'h00, 8'd0, 1'b0};
    vecs[3]  = '{16'hB0FF, 1'b1, 1'b1, 100, 8'h33, 1'b1, 1'b1, 87, 8'hFF, 8'd1, 1'b0};
    vecs[4]  = '{16'h1111, 1'b1, 1'b1, 40,  8'h11, 1'b1, 1'b1, 61, 8'h11, 8'd1, 1'b0};
    vecs[5]  = '{16'h2222, 1'b1, 1'b1, 45,  8'h22, 1'b1, 1'b1, 61, 8'h22, 8'd1, 1'b0};
    vecs[6]  = '{16'h3333, 1'b1, 1'b1, 50,  8'h33, 1'b1, 1'b1, 61, 8'h33, 8'd1, 1'b0};
    vecs[7]  = '{16'hC000, 1'b1, 1'b1, 85,  8'hA5, 1'b1, 1'b1, 87, 8'hA5, 8'd1, 1'b0};
    vecs[8]  = '{16'hC001, 1'b1, 1'b1, 86,  8'h5C, 1'b1, 1'b1, 87, 8'hFF, 8'd2, 1'b0};
    vecs[9]  = '{16'hD000, 1'b1, 1'b1, 59,  8'h9C, 1'b1, 1'b1, 61, 8'h9C, 8'd2, 1'b0};
    vecs[10] = '{16'hE000, 1'b1, 1'b1, -1,  8'h00, 1'b1, 1'b1, 87, 8'hFF, 8'd3, 1'b1};
    vecs[11] = '{16'hE100, 1'b1, 1'b1, 40,  8'h77, 1'b1, 1'b0, 61, 8'hFF, 8'd4, 1'b0};
    vecs[12] = '{16'hF00F, 1'b1, 1'b1, 40,  8'hC3, 1'b1, 1'b1, 61, 8'hC3, 8'd4, 1'b0};

    // Reset state.
    repeat (2) @(negedge clk200);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_data", 32'(a8_data_out), 32'd0);
    check("rst_oe", 32'(a8_data_oe), 32'd0);
    check("rst_timeouts", 32'(timeout_count), 32'd0);
    a8_rst_n = 1'b1;
    repeat (5) @(negedge clk200);
    resync();

    for (int i = 0; i < NVEC; i++) begin
      run_cycle(vecs[i], $sformatf("v%0d", i));
    end

    // Asynchronous reset in the middle of a driven (missed) cycle.
    a8_addr  = 16'hAB00;
    a8_rw_n  = 1'b1;
    page_sel = 1'b1;
    for (int t = 5; t < 95; t++) begin
      if (t == 55) a8_clk = 1'b1;
      @(negedge clk200);
    end
    check("arst_pre_oe", 32'(a8_data_oe), 32'd1);
    check("arst_pre_req", 32'(mem_req), 32'd1);
    #1 a8_rst_n = 1'b0;
    #1;
    check("arst_oe", 32'(a8_data_oe), 32'd0);
    check("arst_req", 32'(mem_req), 32'd0);
    check("arst_timeouts", 32'(timeout_count), 32'd0);
    $display("cycle arst addr=%h oe=%b req=%b timeouts=%0d", a8_addr, a8_data_oe, mem_req, timeout_count);
    page_sel = 1'b0;
    repeat (2) @(negedge clk200);
    a8_rst_n = 1'b1;
    repeat (5) @(negedge clk200);
    resync();
    v_post = '{16'h0102, 1'b1, 1'b1, 40, 8'hE7, 1'b1, 1'b1, 61, 8'hE7, 8'd0, 1'b0};
    run_cycle(v_post, "post_rst");

    // phi2 stops high while driving: driver must release once ticks saturate.
    a8_addr      = 16'h5555;
    a8_rw_n      = 1'b1;
    page_sel     = 1'b1;
    oe_at_127    = -1;
    oe_at_128    = -1;
    stop_data_ok = 1'b1;
    for (int t = 5; t <= 200; t++) begin
      if (t == 127) oe_at_127 = int'(a8_data_oe);
      if (t == 128) oe_at_128 = int'(a8_data_oe);
      if (a8_data_oe && a8_data_out !== 8'h66) stop_data_ok = 1'b0;
      mem_ack   = (t == 40);
      mem_rdata = (t == 40) ? 8'h66 : 8'h00;
      if (t == 55) a8_clk = 1'b1;
      @(negedge clk200);
    end
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    check("stop_oe_127", 32'(oe_at_127), 32'd1);
    check("stop_oe_128", 32'(oe_at_128), 32'd0);
    check("stop_oe_end", 32'(a8_data_oe), 32'd0);
    check("stop_req_end", 32'(mem_req), 32'd0);
    check("stop_data", 32'(stop_data_ok), 32'd1);
    $display("cycle stop addr=%h oe127=%0d oe128=%0d req=%b", a8_addr, oe_at_127, oe_at_128, mem_req);
    resync();
    v_post = '{16'h7F80, 1'b1, 1'b1, 50, 8'h81, 1'b1, 1'b1, 61, 8'h81, 8'd0, 1'b0};
    run_cycle(v_post, "post_stop");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_a8_rd_drive.md
Name: bus_a8_rd_drive

Overview:
Read-side responder for the A8 cartridge bus. It serves A8 read cycles that target FPGA-sourced pages:
- Syncs a8_clk and tracks position within the bus cycle.
- Samples address and r/w at address-valid time.
- Fetches the byte from FPGA-side memory over a req/ack handshake.
- Drives it onto the A8 data bus inside the read-valid window.
It sits beside the bus monitor that raises EXTSEL. The page-select lookup is supplied to it from the page-map.

Parameters:
- TICK_BITS, 7, width of the cycle tick counter.
- TICK_ADDRESS_VALID, 33, tick at which addr, rw_n and page_sel are sampled.
- TICK_DRIVE_ON, 60, earliest tick to enable the data driver.
- TICK_DEADLINE, 85, last tick at which fetched data is accepted for this cycle.
- HOLD_TICKS, 3, ticks after the next falling edge that the driver stays enabled (data hold).
- DEFAULT_DATA, 8'hFF, byte driven when the fetch misses the deadline.

Ports:
- clk200  in  1  200 MHz FPGA clock.
- a8_rst_n  in  1  reset; asynchronous, active-low.
- a8_clk  in  1  A8 phi2 (~1.8 MHz), asynchronous to clk200.
- a8_rw_n  in  1  A8 read/write (1 = read).
- a8_addr  in  16  A8 address bus.
- page_sel  in  1  1 = page a8_addr[15:8] is FPGA-sourced (pagemap lookup).
- mem_req  out  1  fetch request, level-held until mem_ack.
- mem_addr  out  16  fetch address; stable while mem_req = 1.
- mem_ack  in  1  one-cycle acknowledge; mem_rdata valid in the same cycle.
- mem_rdata  in  8  fetched byte.
- a8_data_out  out  8  byte for the A8 data bus.
- a8_data_oe  out  1  data bus driver enable (1 = drive).
- timeout_count  out  8  saturating count of deadline misses.

Behaviour:
- **Reset** (async, a8_rst_n = 0):
  - Sync register = 000, ticks = 0, state = IDLE.
  - mem_req = 0, mem_addr = 0, a8_data_out = 0, a8_data_oe = 0, timeout_count = 0, pending_ack = 0.
  - Reset mid-operation drops oe immediately, with no hold.
- **Clock sync:** 3-stage shift of a8_clk. falling = sync[2:1] == 10. ticks clears to 0 on falling, otherwise increments and saturates at all-ones (no wrap).
- **States:**
  - IDLE: when ticks == TICK_ADDRESS_VALID and a8_rw_n = 1 and page_sel = 1, latch mem_addr = a8_addr, assert mem_req, go FETCH (unless pending_ack = 1, see Late ack). Writes and non-selected pages stay in IDLE.
  - FETCH: on mem_ack, latch a8_data_out = mem_rdata, drop mem_req, go READY. If ticks reaches TICK_DEADLINE without ack, load a8_data_out = DEFAULT_DATA, increment timeout_count (saturate at 255), set pending_ack = 1, go READY. mem_req stays high until the ack arrives.
  - READY: when ticks >= TICK_DRIVE_ON, set a8_data_oe = 1 and go DRIVE. If ack arrived before TICK_DRIVE_ON, the driver enables exactly at TICK_DRIVE_ON.
  - DRIVE: on falling, go HOLD; ticks restarts from 0.
  - HOLD: when ticks == HOLD_TICKS, set a8_data_oe = 0 and go IDLE. A new address-valid sample cannot collide, since HOLD_TICKS < TICK_ADDRESS_VALID.
- **Late ack:** while pending_ack = 1, the next mem_ack drops mem_req, clears pending_ack and discards mem_rdata. A new request is not issued until pending_ack = 0. A selected read arriving meanwhile is treated as a miss: DEFAULT_DATA is driven and timeout_count increments.
- **Lost clock:** if ticks saturates in FETCH, READY or DRIVE, set oe = 0 and go IDLE. mem_req handling is unchanged (still held until ack).
- **Data stability:** a8_data_out changes only in FETCH (on ack or deadline); it is constant while oe = 1.
- **Registered outputs:** all outputs are registered. oe rises one clk200 after the tick condition.

Decomposition:
- Shared package (defines): TICK_ADDRESS_VALID, TICK_DRIVE_ON, TICK_DEADLINE, HOLD_TICKS, state encodings. The tick values are shared with the bus monitor.
- Sub-module a8_cycle_timer: 3-stage sync, rising/falling detect, saturating tick counter. It is reusable by the monitor.

Test Plan:
- **Basic read:** read $A012, page_sel = 1, ack at tick 40 with 8'h5A -> mem_addr = 16'hA012; oe high from tick 61 to falling + 4 clk200; data = 5A throughout.
- **Write / unselected:** write cycle, or read with page_sel = 0 -> mem_req never asserts; oe stays 0.
- **Deadline miss:** ack arrives at tick 100 with 8'h33 -> driven byte = FF; timeout_count = 1; 33 discarded; mem_req drops on ack.
- **Back-to-back reads:** 3 consecutive selected reads with acks of 11, 22, 33 -> each cycle drives its own byte; oe gap ≥ 1 clk200 between cycles.
- **Async reset:** assert a8_rst_n low mid-DRIVE -> oe = 0 and mem_req = 0 with no clk200 edge; after release, next selected read is served normally.
- **Stopped a8_clk:** hold a8_clk high during DRIVE for 200 ticks -> oe drops at tick 127 saturation; state returns to IDLE.
